tile_scheduler: RTL
===================

// Module: tile_scheduler
// PURPOSE
//  Frame-level sequencer for the tile painter. It walks the screen tile by tile in row-major order.
//  For each tile it drives the painter's active/wipe/offset inputs to wipe the tile BRAM, then paint
//  every triangle into it, then hands the tile to the downstream flush (tile BRAM -> framebuffer).
//  Sits between the frame/triangle setup logic and the painter + flush engine.
// PARAMETERS
//  TILE_W         20   tile width in pixels (x_offset step)
//  TILE_H         45   tile height in pixels (y_offset step)
//  TILES_X        16   tiles per row (320 px screen)
//  TILES_Y         4   tile rows (180 px screen)
//  MAX_TRIANGLES 256   sets NT_W = $clog2(MAX_TRIANGLES)
// PORTS
//  clk             in   1     system clock
//  rst             in   1     synchronous, active-high reset
//  frame_start     in   1     pulse: begin a frame; ignored unless idle
//  num_triangles_in in  NT_W  triangle count, sampled on accepted frame_start
//  painter_done    in   1     painter done level (held high while painter in DONE)
//  flush_done      in   1     pulse: flush of current tile complete
//  painter_active  out  1     painter active
//  painter_wipe    out  1     painter wipe request
//  num_triangles   out  NT_W  latched count to painter
//  x_offset        out  9     current tile x origin (tx*TILE_W)
//  y_offset        out  8     current tile y origin (ty*TILE_H)
//  flush_start     out  1     1-cycle pulse: start flushing current tile at x_offset/y_offset
//  busy            out  1     high from accepted frame_start until frame_done
//  frame_done      out  1     1-cycle pulse after last tile's flush_done
// BEHAVIOUR
//  - Reset (also mid-frame): state IDLE; all outputs 0; tx=ty=0; pending handshakes abandoned.
//  - Registered outputs, all driven from state/counters; no comb path from inputs to outputs.
//  - States:
//    - IDLE: on frame_start, latch num_triangles, tx=ty=0, busy=1, -> WIPE.
//    - WIPE: active=1, wipe=1; wait painter_done=1 -> WGAP.
//    - WGAP: active=0, wipe=0, one cycle (returns painter to its RST, clears its done) -> PAINT.
//    - PAINT: active=1, wipe=0; wait painter_done=1 -> PGAP.
//    - PGAP: active=0, one cycle -> FLUSH; flush_start pulses on entry to FLUSH.
//    - FLUSH: wait flush_done -> NEXT.
//    - NEXT: if tx<TILES_X-1, tx++; else tx=0 and ty++. Return to WIPE.
//      After tile (TILES_X-1,TILES_Y-1), go to IDLE with a frame_done pulse and busy=0.
//  - painter_done is sampled only in WIPE/PAINT; it is 0 on entry because active was low the prior cycle.
//  - num_triangles==0: PAINT still entered; painter reports done immediately (unless SKIP_EMPTY below).
//  - Offsets: x_offset=tx*TILE_W, y_offset=ty*TILE_H. Both are registered and updated in NEXT.
//    They stay stable from WIPE through FLUSH.
//  - frame_start while busy: ignored, no queuing.
//  - flush_done outside FLUSH: ignored.
//  - Simultaneous frame_done and frame_start in the same cycle: frame_start is ignored.
// CONFIGURATION
//  TILE_SCHED_SKIP_EMPTY_EN defined:
//    - if the latched num_triangles==0, WGAP goes directly to FLUSH; PAINT/PGAP are skipped.
//    - flush_start timing relative to FLUSH entry is unchanged.
//  TILE_SCHED_SKIP_EMPTY_EN undefined: PAINT is always executed.
// TESTING (TILES_X=2, TILES_Y=2; painter/flush models)
//  1. frame_start, num=3:
//     - offsets visit (0,0),(20,0),(0,45),(20,45) in order.
//     - exactly 4 flush_start pulses, then 1 frame_done; busy low after.
//  2. Per tile: wipe=1 only with active=1; active low exactly 1 cycle between WIPE and PAINT,
//     and between PAINT and flush_start.
//  3. painter_done stuck high for 10 cycles in WIPE -> exactly 1 transition to WGAP, no double-advance.
//  4. frame_start pulsed mid-frame (tile 2):
//     - ignored, no restart, num_triangles unchanged.
//     - late flush_done during PAINT ignored.
//  5. rst asserted during FLUSH of tile 1:
//     - next cycle all outputs 0, IDLE.
//     - a new frame_start restarts at (0,0).
//  6. num=0: with SKIP_EMPTY_EN, no cycle with active=1 & wipe=0; without it, PAINT occurs once per tile.

Source files
------------

// File: rtl/tile_scheduler.sv
// Frame sequencer for the tile painter: per tile, wipe -> paint -> flush, row-major over the screen.
// Latency: outputs are registered; one state step per cycle, each phase waits on painter_done / flush_done.
// Backpressure: frame_start is dropped while busy; painter_done and flush_done are only honoured in their wait states.
// Optional: TILE_SCHED_SKIP_EMPTY_EN skips PAINT/PGAP for tiles of a frame whose latched triangle count is zero.
module tile_scheduler #(
    parameter int TILE_W        = 20,
    parameter int TILE_H        = 45,
    parameter int TILES_X       = 16,
    parameter int TILES_Y       = 4,
    parameter int MAX_TRIANGLES = 256,
    localparam int NT_W         = $clog2(MAX_TRIANGLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic [NT_W-1:0] num_triangles_in,
    input  logic            painter_done,
    input  logic            flush_done,
    output logic            painter_active,
    output logic            painter_wipe,
    output logic [NT_W-1:0] num_triangles,
    output logic [8:0]      x_offset,
    output logic [7:0]      y_offset,
    output logic            flush_start,
    output logic            busy,
    output logic            frame_done
);

    localparam int TX_W = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TY_W = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WIPE  = 3'd1;
    localparam logic [2:0] S_WGAP  = 3'd2;
    localparam logic [2:0] S_PAINT = 3'd3;
    localparam logic [2:0] S_PGAP  = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [TX_W-1:0] tx_q, tx_d;
    logic [TY_W-1:0] ty_q, ty_d;
    logic [8:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    logic [NT_W-1:0] ntri_q, ntri_d;
    logic            active_q, active_d;
    logic            wipe_q, wipe_d;
    logic            busy_q, busy_d;
    logic            flush_start_q, flush_start_d;
    logic            frame_done_q, frame_done_d;
    logic            last_col, last_row;

    assign last_col = (tx_q == TX_W'(TILES_X - 1));
    assign last_row = (ty_q == TY_W'(TILES_Y - 1));

    // Next-state logic; every output register is derived from the next state so outputs never see inputs combinationally.
    always_comb begin
        state_d       = state_q;
        tx_d          = tx_q;
        ty_d          = ty_q;
        x_d           = x_q;
        y_d           = y_q;
        ntri_d        = ntri_q;
        flush_start_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A frame_start coinciding with the frame_done pulse belongs to the finished frame and is dropped.
                if (frame_start && !frame_done_q) begin
                    state_d = S_WIPE;
                    ntri_d  = num_triangles_in;
                    tx_d    = '0;
                    ty_d    = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_WIPE: begin
                if (painter_done) begin
                    state_d = S_WGAP;
                end
            end
            S_WGAP: begin
`ifdef TILE_SCHED_SKIP_EMPTY_EN
                if (ntri_q == '0) begin
                    state_d       = S_FLUSH;
                    flush_start_d = 1'b1;
                end else begin
                    state_d = S_PAINT;
                end
`else
                state_d = S_PAINT;
`endif
            end
            S_PAINT: begin
                if (painter_done) begin
                    state_d = S_PGAP;
                end
            end
            S_PGAP: begin
                state_d       = S_FLUSH;
                flush_start_d = 1'b1;
            end
            S_FLUSH: begin
                if (flush_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_col && last_row) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                    tx_d         = '0;
                    ty_d         = '0;
                    x_d          = '0;
                    y_d          = '0;
                end else if (!last_col) begin
                    state_d = S_WIPE;
                    tx_d    = tx_q + 1'b1;
                    x_d     = x_q + 9'(TILE_W);
                end else begin
                    state_d = S_WIPE;
                    tx_d    = '0;
                    x_d     = '0;
                    ty_d    = ty_q + 1'b1;
                    y_d     = y_q + 8'(TILE_H);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        active_d = (state_d == S_WIPE) || (state_d == S_PAINT);
        wipe_d   = (state_d == S_WIPE);
        busy_d   = (state_d != S_IDLE);
    end

    // State, counters and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tx_q          <= '0;
            ty_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            ntri_q        <= '0;
            active_q      <= 1'b0;
            wipe_q        <= 1'b0;
            busy_q        <= 1'b0;
            flush_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            ty_q          <= ty_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ntri_q        <= ntri_d;
            active_q      <= active_d;
            wipe_q        <= wipe_d;
            busy_q        <= busy_d;
            flush_start_q <= flush_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign painter_active = active_q;
    assign painter_wipe   = wipe_q;
    assign num_triangles  = ntri_q;
    assign x_offset       = x_q;
    assign y_offset       = y_q;
    assign flush_start    = flush_start_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

endmodule
